// File: rtl/soc_pm_data_xfer_if.sv
// Request/response and pixel-matrix bus bundle for soc_pm_data_xfer.
// Parity lines exist only when SOC_PM_DATA_XFER_PARITY_EN is defined.
interface soc_pm_data_xfer_if #(
  parameter int DW   = 32,
  parameter int N_CH = 1,
  parameter int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) ();
  logic                 req_valid;
  logic                 req_ready;
  logic [DW-1:0]        req_data;
  logic [CW-1:0]        req_ch;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_err;
  logic [N_CH*DW-1:0]   pm_din;
  logic [N_CH*DW-1:0]   pm_dout;
  logic [N_CH-1:0]      pm_strobe;
`ifdef SOC_PM_DATA_XFER_PARITY_EN
  logic [N_CH-1:0]      pm_din_par;
  logic [N_CH-1:0]      pm_dout_par;
`endif

  modport slave (
    input  req_valid, req_data, req_ch, rsp_ready, pm_dout,
`ifdef SOC_PM_DATA_XFER_PARITY_EN
    input  pm_dout_par,
    output pm_din_par,
`endif
    output req_ready, rsp_valid, rsp_data, rsp_err, pm_din, pm_strobe
  );

  modport master (
    output req_valid, req_data, req_ch, rsp_ready, pm_dout,
`ifdef SOC_PM_DATA_XFER_PARITY_EN
    output pm_dout_par,
    input  pm_din_par,
`endif
    input  req_ready, rsp_valid, rsp_data, rsp_err, pm_din, pm_strobe
  );
endinterface

// File: rtl/soc_pm_data_xfer.sv
// Pixel-matrix write/strobe/capture sequencer: one request drives a channel, pulses its strobe, reads back.
// Optional even-parity on the matrix bus is enabled by defining SOC_PM_DATA_XFER_PARITY_EN.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a request
// DRIVE  | pm_din for the target channel settles for one cycle
// STROBE | pm_strobe[ch] high for STB_CYCLES cycles
// SETTLE | wait SETTLE_CYCLES cycles (skipped when 0), then capture pm_dout
// RESP   | rsp_valid held until rsp_ready
module soc_pm_data_xfer #(
  parameter int DW            = 32,
  parameter int N_CH          = 1,
  parameter int STB_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  soc_pm_data_xfer_if.slave    bus
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {IDLE, DRIVE, STROBE, SETTLE, RESP} state_t;

  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [CW-1:0]        r_ch;
  logic                 r_legal;
  logic [N_CH*DW-1:0]   r_din;
  logic [N_CH-1:0]      r_strobe;
  logic                 r_ready;
  logic                 r_rsp_valid;
  logic [DW-1:0]        r_rsp_data;
  logic                 r_rsp_err;

  logic                 w_req_legal;
  logic [N_CH-1:0]      w_req_sel;
  logic [N_CH-1:0]      w_cur_sel;
  logic [DW-1:0]        w_dout_sel;
  logic                 w_rsp_err_nxt;

`ifdef SOC_PM_DATA_XFER_PARITY_EN
  logic [N_CH-1:0]      r_din_par;
  logic                 w_dout_par_sel;
  logic                 w_par_err;
`endif

  // Out-of-range channels select nothing, so capture yields zero and no strobe bit fires.
  always_comb begin
    w_req_legal = (32'(bus.req_ch) < 32'(N_CH));
    w_req_sel   = '0;
    w_cur_sel   = '0;
    w_dout_sel  = '0;
`ifdef SOC_PM_DATA_XFER_PARITY_EN
    w_dout_par_sel = 1'b0;
`endif
    for (int k = 0; k < N_CH; k++) begin
      if (w_req_legal && (bus.req_ch == CW'(k))) begin
        w_req_sel[k] = 1'b1;
      end
      if (r_legal && (r_ch == CW'(k))) begin
        w_cur_sel[k] = 1'b1;
        w_dout_sel   = bus.pm_dout[k*DW +: DW];
`ifdef SOC_PM_DATA_XFER_PARITY_EN
        w_dout_par_sel = bus.pm_dout_par[k];
`endif
      end
    end
`ifdef SOC_PM_DATA_XFER_PARITY_EN
    w_par_err     = r_legal && ((^w_dout_sel) != w_dout_par_sel);
    w_rsp_err_nxt = !r_legal || w_par_err;
`else
    w_rsp_err_nxt = !r_legal;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_ch        <= '0;
      r_legal     <= 1'b0;
      r_din       <= '0;
      r_strobe    <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
`ifdef SOC_PM_DATA_XFER_PARITY_EN
      r_din_par   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_ch    <= bus.req_ch;
            r_legal <= w_req_legal;
            for (int k = 0; k < N_CH; k++) begin
              if (w_req_sel[k]) begin
                r_din[k*DW +: DW] <= bus.req_data;
`ifdef SOC_PM_DATA_XFER_PARITY_EN
                r_din_par[k] <= ^bus.req_data;
`endif
              end
            end
            r_ready <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          r_strobe <= w_cur_sel;
          r_cnt    <= 8'(STB_CYCLES - 1);
          r_state  <= STROBE;
        end
        STROBE: begin
          if (r_cnt == 8'd0) begin
            r_strobe <= '0;
            if (SETTLE_CYCLES == 0) begin
              r_rsp_data  <= w_dout_sel;
              r_rsp_err   <= w_rsp_err_nxt;
              r_rsp_valid <= 1'b1;
              r_cnt       <= 8'd0;
              r_state     <= RESP;
            end else begin
              r_cnt   <= 8'(SETTLE_CYCLES - 1);
              r_state <= SETTLE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        SETTLE: begin
          if (r_cnt == 8'd0) begin
            r_rsp_data  <= w_dout_sel;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_cnt       <= 8'd0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_strobe    <= '0;
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_cnt       <= 8'd0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.pm_din    = r_din;
  assign bus.pm_strobe = r_strobe;
`ifdef SOC_PM_DATA_XFER_PARITY_EN
  assign bus.pm_din_par = r_din_par;
`endif

endmodule

// File: tb/tb_soc_pm_data_xfer.sv
// Bench for soc_pm_data_xfer: three configurations checked every cycle against a timeline model,
// plus directed literal checks. Parity checks are added when SOC_PM_DATA_XFER_PARITY_EN is defined.
module tb_soc_pm_data_xfer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int p_nch[3] = '{1, 4, 3};
  int p_stb[3] = '{2, 1, 2};
  int p_set[3] = '{1, 0, 1};

  logic         req_valid[3];
  logic [31:0]  req_data[3];
  logic [1:0]   req_ch[3];
  logic         rsp_ready[3];
  logic [127:0] pm_dout[3];
  logic [3:0]   pm_dout_par[3];

  logic [127:0] din_w[3];
  logic [3:0]   stb_w[3];
  logic         rdy_w[3], rv_w[3], err_w[3];
  logic [31:0]  rd_w[3];
`ifdef SOC_PM_DATA_XFER_PARITY_EN
  logic [3:0]   dpar_w[3];
`endif

  int vec = 0;
  int miss = 0;

  soc_pm_data_xfer_if #(.DW(32), .N_CH(1)) if0 ();
  soc_pm_data_xfer_if #(.DW(32), .N_CH(4)) if1 ();
  soc_pm_data_xfer_if #(.DW(32), .N_CH(3)) if2 ();

  soc_pm_data_xfer #(.DW(32), .N_CH(1), .STB_CYCLES(2), .SETTLE_CYCLES(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  soc_pm_data_xfer #(.DW(32), .N_CH(4), .STB_CYCLES(1), .SETTLE_CYCLES(0))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  soc_pm_data_xfer #(.DW(32), .N_CH(3), .STB_CYCLES(2), .SETTLE_CYCLES(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.req_valid = req_valid[0];
  assign if0.req_data  = req_data[0];
  assign if0.req_ch    = req_ch[0][0:0];
  assign if0.rsp_ready = rsp_ready[0];
  assign if0.pm_dout   = pm_dout[0][31:0];
  assign din_w[0] = {96'b0, if0.pm_din};
  assign stb_w[0] = {3'b0, if0.pm_strobe};
  assign rdy_w[0] = if0.req_ready;
  assign rv_w[0]  = if0.rsp_valid;
  assign rd_w[0]  = if0.rsp_data;
  assign err_w[0] = if0.rsp_err;

  assign if1.req_valid = req_valid[1];
  assign if1.req_data  = req_data[1];
  assign if1.req_ch    = req_ch[1];
  assign if1.rsp_ready = rsp_ready[1];
  assign if1.pm_dout   = pm_dout[1];
  assign din_w[1] = if1.pm_din;
  assign stb_w[1] = if1.pm_strobe;
  assign rdy_w[1] = if1.req_ready;
  assign rv_w[1]  = if1.rsp_valid;
  assign rd_w[1]  = if1.rsp_data;
  assign err_w[1] = if1.rsp_err;

  assign if2.req_valid = req_valid[2];
  assign if2.req_data  = req_data[2];
  assign if2.req_ch    = req_ch[2];
  assign if2.rsp_ready = rsp_ready[2];
  assign if2.pm_dout   = pm_dout[2][95:0];
  assign din_w[2] = {32'b0, if2.pm_din};
  assign stb_w[2] = {1'b0, if2.pm_strobe};
  assign rdy_w[2] = if2.req_ready;
  assign rv_w[2]  = if2.rsp_valid;
  assign rd_w[2]  = if2.rsp_data;
  assign err_w[2] = if2.rsp_err;

`ifdef SOC_PM_DATA_XFER_PARITY_EN
  assign if0.pm_dout_par = pm_dout_par[0][0:0];
  assign if1.pm_dout_par = pm_dout_par[1];
  assign if2.pm_dout_par = pm_dout_par[2][2:0];
  assign dpar_w[0] = {3'b0, if0.pm_din_par};
  assign dpar_w[1] = if1.pm_din_par;
  assign dpar_w[2] = {1'b0, if2.pm_din_par};
`endif

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s[%0d] t=%0t actual=%h required=%h", nm, idx, $time, act, exp);
    end
  endtask

  // Timeline model: a request accepted in cycle T strobes in T+2..T+1+STB,
  // responds from T+2+STB+SET, and frees the block the cycle after the handshake.
  int           cyc = 0;
  bit           busy[3];
  bit           legal[3];
  bit           rvexp[3];
  int           acc[3];
  int           mch[3];
  logic [127:0] exp_din[3] = '{default: '0};
  logic [31:0]  exp_rd[3]  = '{default: '0};
  logic         exp_err[3] = '{default: 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        busy[i] = 1'b0; rvexp[i] = 1'b0; exp_din[i] = '0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (!busy[i]) begin
          if (req_valid[i]) begin
            busy[i]  = 1'b1;
            acc[i]   = cyc - 1;
            mch[i]   = int'(req_ch[i]);
            legal[i] = (mch[i] < p_nch[i]);
            if (legal[i]) exp_din[i][mch[i]*32 +: 32] = req_data[i];
          end
        end else if (rvexp[i] && rsp_ready[i]) begin
          busy[i]  = 1'b0;
          rvexp[i] = 1'b0;
        end else if (cyc == acc[i] + 2 + p_stb[i] + p_set[i]) begin
          rvexp[i]   = 1'b1;
          exp_rd[i]  = legal[i] ? pm_dout[i][mch[i]*32 +: 32] : 32'h0;
          exp_err[i] = !legal[i];
`ifdef SOC_PM_DATA_XFER_PARITY_EN
          if (legal[i] && ((^pm_dout[i][mch[i]*32 +: 32]) != pm_dout_par[i][mch[i]]))
            exp_err[i] = 1'b1;
`endif
        end
      end
    end
  end

  always @(posedge clk) begin : cmp
    logic [3:0] es;
    #3;
    for (int i = 0; i < 3; i++) begin
      es = 4'b0;
      if (busy[i] && legal[i] && cyc >= acc[i] + 2 && cyc <= acc[i] + 1 + p_stb[i])
        es[mch[i]] = 1'b1;
      chk("req_ready", i, rdy_w[i], !busy[i]);
      chk("rsp_valid", i, rv_w[i], rvexp[i]);
      chk("pm_strobe", i, stb_w[i], es);
      chk("pm_din", i, din_w[i], exp_din[i]);
      if (rvexp[i]) begin
        chk("rsp_data", i, rd_w[i], exp_rd[i]);
        chk("rsp_err", i, err_w[i], exp_err[i]);
      end
`ifdef SOC_PM_DATA_XFER_PARITY_EN
      for (int k = 0; k < p_nch[i]; k++)
        chk("pm_din_par", i, dpar_w[i][k], ^exp_din[i][k*32 +: 32]);
`endif
    end
  end

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int i, input logic [31:0] d, input logic [1:0] ch);
    req_valid[i] = 1'b1;
    req_data[i]  = d;
    req_ch[i]    = ch;
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_data[i] = '0; req_ch[i] = '0;
      rsp_ready[i] = 1'b1; pm_dout[i] = '0; pm_dout_par[i] = '0;
    end
    nc(2);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, rdy_w[i], 1'b1);
      chk("rst_rv", i, rv_w[i], 1'b0);
      chk("rst_rd", i, rd_w[i], 32'h0);
      chk("rst_err", i, err_w[i], 1'b0);
      chk("rst_din", i, din_w[i], 128'h0);
      chk("rst_stb", i, stb_w[i], 4'h0);
    end
    rst_n = 1'b1;
    nc(2);

    // Default configuration, basic transfer timing.
    pm_dout[0] = 128'h12345678;
    chk("t1_ready", 0, rdy_w[0], 1'b1);
    send(0, 32'hA5A5_0001, 2'd0);
    chk("t1_din", 0, din_w[0], 128'hA5A5_0001);
    chk("t1_stb_t1", 0, stb_w[0], 4'h0);
    nc(1); chk("t1_stb_t2", 0, stb_w[0], 4'h1);
    nc(1); chk("t1_stb_t3", 0, stb_w[0], 4'h1);
    nc(1); chk("t1_stb_t4", 0, stb_w[0], 4'h0); chk("t1_rv_t4", 0, rv_w[0], 1'b0);
    nc(1); chk("t1_rv_t5", 0, rv_w[0], 1'b1);
    chk("t1_rd", 0, rd_w[0], 32'h1234_5678); chk("t1_err", 0, err_w[0], 1'b0);
    nc(1); chk("t1_rv_t6", 0, rv_w[0], 1'b0); chk("t1_rdy_t6", 0, rdy_w[0], 1'b1);

    // Four channels, single-cycle strobe, no settle.
    pm_dout[1] = {32'h44, 32'h33, 32'h22, 32'h11};
    send(1, 32'hB1, 2'd1);
    nc(3);
    send(1, 32'hC2, 2'd2);
    chk("t2_din", 1, din_w[1], {32'h0, 32'hC2, 32'hB1, 32'h0});
    nc(1); chk("t2_stb", 1, stb_w[1], 4'b0100); chk("t2_rv_t2", 1, rv_w[1], 1'b0);
    nc(1); chk("t2_stb_off", 1, stb_w[1], 4'b0000); chk("t2_rv_t3", 1, rv_w[1], 1'b1);
    chk("t2_rd", 1, rd_w[1], 32'h33);
    nc(1); chk("t2_rdy", 1, rdy_w[1], 1'b1);

    // Response back-pressure; request inputs and pm_dout wiggle without effect.
    rsp_ready[0] = 1'b0;
    pm_dout[0] = 128'hDEAD_BEEF;
    send(0, 32'h5, 2'd0);
    nc(4);
    for (int k = 0; k < 10; k++) begin
      chk("t3_rv", 0, rv_w[0], 1'b1);
      chk("t3_rd", 0, rd_w[0], 32'hDEAD_BEEF);
      chk("t3_rdy", 0, rdy_w[0], 1'b0);
      if (k == 2) begin req_valid[0] = 1'b1; req_data[0] = 32'hFFFF_FFFF; pm_dout[0] = '0; end
      if (k == 5) req_valid[0] = 1'b0;
      nc(1);
    end
    chk("t3_din", 0, din_w[0], 128'h5);
    rsp_ready[0] = 1'b1;
    nc(1); chk("t3_rdy_rel", 0, rdy_w[0], 1'b1); chk("t3_rv_rel", 0, rv_w[0], 1'b0);

    // Three channels: legal request, then out-of-range channel 3.
    pm_dout[2] = {32'h0, 32'h0C, 32'h0B, 32'h0A};
    send(2, 32'h77, 2'd2);
    nc(4); chk("t4_rv", 2, rv_w[2], 1'b1); chk("t4_rd", 2, rd_w[2], 32'h0C); chk("t4_err", 2, err_w[2], 1'b0);
    nc(1);
    send(2, 32'h99, 2'd3);
    chk("t4b_din", 2, din_w[2], {32'h0, 32'h77, 32'h0, 32'h0});
    nc(1); chk("t4b_stb2", 2, stb_w[2], 4'h0);
    nc(1); chk("t4b_stb3", 2, stb_w[2], 4'h0);
    nc(1); chk("t4b_rv4", 2, rv_w[2], 1'b0);
    nc(1); chk("t4b_rv5", 2, rv_w[2], 1'b1);
    chk("t4b_rd", 2, rd_w[2], 32'h0); chk("t4b_err", 2, err_w[2], 1'b1);
    nc(1); chk("t4b_rdy", 2, rdy_w[2], 1'b1);

    // Reset in the middle of the strobe pulse.
    pm_dout[0] = 128'h0F0F_0F0F;
    send(0, 32'h1111, 2'd0);
    nc(1); chk("t5_stb", 0, stb_w[0], 4'h1);
    #1 rst_n = 1'b0;
    #1 chk("t5_stb_rst", 0, stb_w[0], 4'h0);
    chk("t5_din_rst", 0, din_w[0], 128'h0);
    nc(1);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      nc(1);
      chk("t5_no_rv", 0, rv_w[0], 1'b0);
      chk("t5_rdy", 0, rdy_w[0], 1'b1);
    end
    pm_dout[0] = 128'h3333;
    send(0, 32'h2222, 2'd0);
    nc(4); chk("t5_rv", 0, rv_w[0], 1'b1); chk("t5_rd", 0, rd_w[0], 32'h3333); chk("t5_err", 0, err_w[0], 1'b0);
    nc(1);

`ifdef SOC_PM_DATA_XFER_PARITY_EN
    pm_dout[0] = 128'h1;
    pm_dout_par[0] = 4'h0;
    send(0, 32'h7, 2'd0);
    chk("t6_dpar", 0, dpar_w[0], 4'h1);
    nc(4); chk("t6_err_bad", 0, err_w[0], 1'b1); chk("t6_rd", 0, rd_w[0], 32'h1);
    nc(1);
    pm_dout_par[0] = 4'h1;
    send(0, 32'h3, 2'd0);
    chk("t6_dpar2", 0, dpar_w[0], 4'h0);
    nc(4); chk("t6_err_ok", 0, err_w[0], 1'b0);
    nc(1);
`endif

    nc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/soc_pm_data_xfer.md
SOC_PM_DATA_XFER -- requirements
Module: soc_pm_data_xfer

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width of one pixel-matrix channel.
REQ-002 The block SHALL have parameter N_CH, default 1, meaning number of pixel-matrix data channels; CW = max(1, clog2(N_CH)).
REQ-003 The block SHALL have parameter STB_CYCLES, default 2, meaning strobe pulse length in cycles, legal range 1..255.
REQ-004 The block SHALL have parameter SETTLE_CYCLES, default 1, meaning wait after strobe before capture, legal range 0..255.
REQ-005 The block SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid, input, 1, request present.
REQ-008 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-009 The block SHALL have port req_data, input, DW, word to drive into the matrix.
REQ-010 The block SHALL have port req_ch, input, CW, target channel index.
REQ-011 The block SHALL have port rsp_valid, output, 1, response present.
REQ-012 The block SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-013 The block SHALL have port rsp_data, output, DW, word captured from the matrix.
REQ-014 The block SHALL have port rsp_err, output, 1, response error flag.
REQ-015 The block SHALL have port pm_din, output, N_CH*DW, matrix input data, channel k at bits [k*DW +: DW].
REQ-016 The block SHALL have port pm_dout, input, N_CH*DW, matrix output data, same packing as pm_din.
REQ-017 The block SHALL have port pm_strobe, output, N_CH, per-channel latch strobe, active high.

Function
REQ-018 The FSM SHALL have states IDLE, DRIVE, STROBE, SETTLE and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-020 On acceptance in cycle T: req_data and req_ch SHALL be registered; state SHALL go to DRIVE; pm_din[ch] SHALL show req_data from T+1.
REQ-021 DRIVE SHALL last one cycle, then go to STROBE.
REQ-022 STROBE SHALL last exactly STB_CYCLES cycles, with pm_strobe[ch]=1 and all other strobe bits 0 (cycles T+2 .. T+1+STB_CYCLES).
REQ-023 SETTLE SHALL last SETTLE_CYCLES cycles; with SETTLE_CYCLES=0 it SHALL be skipped.
REQ-024 On the clock edge that leaves the last STROBE/SETTLE cycle, rsp_data SHALL capture pm_dout[ch]; state SHALL go to RESP; rsp_valid SHALL be 1 from cycle T+2+STB_CYCLES+SETTLE_CYCLES.
REQ-025 In RESP, rsp_valid, rsp_data and rsp_err SHALL hold until rsp_valid && rsp_ready; the state SHALL then return to IDLE with rsp_valid=0 in the next cycle.
REQ-026 req_ready SHALL stay 0 while in RESP, so no back-to-back overlap occurs; the minimum request spacing is 3+STB_CYCLES+SETTLE_CYCLES cycles.
REQ-027 Unselected pm_din channels SHALL hold their last driven value; pm_strobe SHALL be all-zero outside STROBE.
REQ-028 If req_ch >= N_CH, the request SHALL still be accepted and sequenced with identical timing, with no pm_din or pm_strobe change, rsp_data=0 and rsp_err=1.
REQ-029 Internal cycle counters SHALL be 8 bits wide and SHALL reload on each state entry, with no wrap within a state.
REQ-030 req_* inputs changing while not in IDLE SHALL have no effect.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_err=0, pm_din=0, pm_strobe=0, counters=0.
REQ-032 Reset asserted mid-transfer SHALL abort it immediately, dropping pm_strobe in the same cycle, and SHALL produce no response.

Configuration
REQ-033 When macro SOC_PM_DATA_XFER_PARITY_EN is defined, the block SHALL add ports pm_din_par (output, N_CH) and pm_dout_par (input, N_CH).
REQ-034 With SOC_PM_DATA_XFER_PARITY_EN defined, pm_din_par[ch] SHALL be the even parity of the driven word, updated with pm_din.
REQ-035 With SOC_PM_DATA_XFER_PARITY_EN defined, at capture the block SHALL check pm_dout_par[ch] against the parity of pm_dout[ch], and a mismatch SHALL set rsp_err=1.
REQ-036 Without SOC_PM_DATA_XFER_PARITY_EN, the parity ports and logic SHALL be absent, and rsp_err SHALL reflect only REQ-028.

Verification
REQ-037 Bench: defaults, accept req_data=0xA5A5_0001 at T, pm_dout=0x1234_5678 -> pm_din=0xA5A5_0001 at T+1, pm_strobe=1 at T+2..T+3, rsp_valid at T+5, rsp_data=0x1234_5678, rsp_err=0.
REQ-038 Bench: N_CH=4, STB_CYCLES=1, SETTLE_CYCLES=0, req_ch=2 -> only pm_strobe[2] pulses for 1 cycle, rsp_valid at T+3, pm_din channels 0/1/3 unchanged.
REQ-039 Bench: rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_data stable and req_ready=0 throughout; IDLE is entered one cycle after rsp_ready=1.
REQ-040 Bench: N_CH=3, req_ch=3 -> no strobe, rsp_data=0, rsp_err=1, timing identical to a legal request.
REQ-041 Bench: rst_n driven low during STROBE -> pm_strobe=0 immediately, no rsp_valid after release, the next request completes normally.
REQ-042 Bench: with SOC_PM_DATA_XFER_PARITY_EN, pm_dout=0x0000_0001 and pm_dout_par=0 -> rsp_err=1; with pm_dout_par=1 -> rsp_err=0.
